// File: rtl/fixed_point_serial_subtractor.sv
// Bit-serial two's complement subtractor (a + ~b + 1), LSB first, one bit per clock.
// Operands and result move over valid/ready handshakes; signed overflow is flagged.
module fixed_point_serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] result,
  output logic                    overflow,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       sa_q, sa_d;
  logic [WIDTH-1:0]       sb_q, sb_d;
  logic [WIDTH-1:0]       sr_q, sr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   carry_q, carry_d;
  logic                   a_msb_q, a_msb_d;
  logic                   b_msb_q, b_msb_d;
  logic signed [WIDTH-1:0] result_q, result_d;
  logic                   ovf_q, ovf_d;
  logic                   s_bit;

  assign s_bit = sa_q[0] ^ sb_q[0] ^ carry_q;

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = ~b;
          carry_d = 1'b1;
          cnt_d   = CNT_W'(WIDTH - 1);
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = (sa_q[0] & sb_q[0]) | (sa_q[0] & carry_q) | (sb_q[0] & carry_q);
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        sr_d    = {s_bit, sr_q[WIDTH-1:1]};
        cnt_d   = cnt_q - CNT_W'(1);
        // Counter at zero means this cycle produces the sign bit of the difference.
        if (cnt_q == '0) begin
          result_d = {s_bit, sr_q[WIDTH-1:1]};
          ovf_d    = (a_msb_q != b_msb_q) && (s_bit != a_msb_q);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign result    = result_q;
  assign overflow  = ovf_q;

endmodule
